decode_pipe_reg: RTL and testbench
==================================

Name: decode_pipe_reg

Overview:
Parametrised decode-to-execute pipeline register that carries opcode, destination, two source register addresses and immediate data. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and bubble (NOP) injection. It sits between the decoder and the execute stage and runs at full throughput under backpressure, with no combinational path from out_ready_r to in_ready_r.

Parameters:
OPCODE_W, 5, opcode field width
REG_ADDR_W, 4, width of dest/s1/s2 register address fields
DATA_W, 32, immediate data width
NOP_OPCODE, 0, opcode driven on the outputs whenever the stage holds no valid instruction

Ports:
clk_r  input  1  clock, rising edge
reset_r  input  1  asynchronous, active-high reset
in_valid_r  input  1  upstream instruction valid
in_ready_r  output  1  stage can accept; equals NOT skid_valid, driven from a flop
opcode_in_d_r  input  OPCODE_W  opcode
dest_in_d_r  input  REG_ADDR_W  destination register
s1_in_d_r  input  REG_ADDR_W  source 1
s2_in_d_r  input  REG_ADDR_W  source 2
ime_data_in_d_r  input  DATA_W  immediate
flush_r  input  1  synchronous pipeline flush
out_valid_r  output  1  output instruction valid (main slot occupied)
out_ready_r  input  1  downstream accepts
opcode_out_d_r  output  OPCODE_W  registered opcode
dest_out_d_r  output  REG_ADDR_W  registered dest
s1_out_d_r  output  REG_ADDR_W  registered s1
s2_out_d_r  output  REG_ADDR_W  registered s2
ime_data_out_d_r  output  DATA_W  registered immediate
occupancy_r  output  2  number of held instructions, 0..2

Behaviour:
- Payload = {opcode, dest, s1, s2, imm}. PAYLOAD_W = OPCODE_W + 3*REG_ADDR_W + DATA_W.
- State: main slot (drives the outputs) plus main_valid; skid slot plus skid_valid. out_valid_r = main_valid.
- Handshakes: accept = in_valid_r & in_ready_r; drain = out_valid_r & out_ready_r.
- Reset (async, active-high): main_valid = 0, skid_valid = 0, occupancy_r = 0, in_ready_r = 1. opcode_out = NOP_OPCODE; dest, s1, s2 and imm outputs = 0. Input is ignored while reset_r is high.
- Latency: an accepted instruction appears on the outputs on the next rising edge when the main slot is empty or draining in that cycle.
- Next-state rules, in priority order:
  1. flush_r = 1: both valid bits cleared; outputs load NOP/zeros; any same-cycle accept is discarded; a same-cycle drain still counts as a completed transfer downstream.
  2. Skid valid and drain: skid moves to main; skid_valid = 0. in_ready_r is 0 this cycle, so no accept.
  3. Accept and (main empty or drain): input loads into main; main_valid = 1.
  4. Accept, main valid and no drain: input loads into skid; skid_valid = 1 (in_ready_r goes 0 next cycle).
  5. Drain with no accept and skid empty: main_valid = 0; outputs load NOP/zeros (bubble).
  6. Otherwise: hold all state.
- Output payload is never stale: when out_valid_r = 0, opcode = NOP_OPCODE and all other fields are 0.
- Ordering: the skid entry is always older than any new input. Instructions leave in acceptance order; none is lost or duplicated.
- occupancy_r = main_valid + skid_valid, registered. A value of 2 implies in_ready_r = 0.
- Throughput: 1 instruction per cycle sustained when out_ready_r = 1.
- No input-to-output combinational paths.

Decomposition:
- Package decode_pipe_pkg: default widths, NOP_OPCODE, PAYLOAD_W localparam, and pack/unpack functions for the payload.
- One sub-module, pipe_payload_slot: a PAYLOAD_W register with load and clear-to-NOP controls and async active-high reset. It is instantiated twice, once for main and once for skid.
- The control logic (valid bits, ready, occupancy) stays in the top module.

Test Plan:
- Reset mid-stream: hold 2 entries, then pulse reset_r async mid-cycle -> out_valid_r = 0, opcode_out = NOP_OPCODE, imm = 0, occupancy_r = 0, in_ready_r = 1 immediately.
- Streaming: out_ready_r = 1; send opcodes 1..8 with imm = 0x1000 + n on consecutive cycles -> each appears 1 cycle later, 8 transfers in 8 cycles, occupancy_r stays at or below 1.
- Backpressure: out_ready_r = 0; send opcode 3 (dest 5, s1 6, s2 7, imm 0xDEADBEEF), then opcode 4 -> occupancy_r = 2, in_ready_r = 0. Raise out_ready_r -> opcode 3 then opcode 4 drain in order on consecutive cycles.
- Flush with full skid plus same-cycle accept: occupancy_r = 2, assert flush_r -> next cycle out_valid_r = 0, opcode NOP, occupancy_r = 0, and the flushed instructions never appear.
- Bubble: single instruction opcode 9 drained with no new input -> next cycle out_valid_r = 0, opcode_out = NOP_OPCODE, dest = s1 = s2 = 0, imm = 0.
- Random valid/ready/flush for 10k cycles against a queue model -> order preserved, occupancy matches the model, in_ready_r = NOT (occupancy == 2).

Source files
------------

// File: rtl/decode_pipe_pkg.sv
// rtl/decode_pipe_pkg.sv - default widths, NOP opcode and payload pack/unpack helpers for the decode pipe register
package decode_pipe_pkg;

    localparam int OPCODE_W_DEF   = 5;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int DATA_W_DEF     = 32;
    localparam int NOP_OPCODE_DEF = 0;
    localparam int PAYLOAD_W      = OPCODE_W_DEF + 3 * REG_ADDR_W_DEF + DATA_W_DEF;

    typedef struct packed {
        logic [OPCODE_W_DEF-1:0]   opcode;
        logic [REG_ADDR_W_DEF-1:0] dest;
        logic [REG_ADDR_W_DEF-1:0] s1;
        logic [REG_ADDR_W_DEF-1:0] s2;
        logic [DATA_W_DEF-1:0]     imm;
    } payload_t;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [OPCODE_W_DEF-1:0]   opcode,
        input logic [REG_ADDR_W_DEF-1:0] dest,
        input logic [REG_ADDR_W_DEF-1:0] s1,
        input logic [REG_ADDR_W_DEF-1:0] s2,
        input logic [DATA_W_DEF-1:0]     imm
    );
        return {opcode, dest, s1, s2, imm};
    endfunction

    function automatic payload_t unpack_payload(input logic [PAYLOAD_W-1:0] bits);
        return payload_t'(bits);
    endfunction

endpackage

// File: rtl/pipe_payload_slot.sv
// rtl/pipe_payload_slot.sv - payload register with load and clear-to-NOP controls
module pipe_payload_slot #(
    parameter int             W         = 49,
    parameter logic [W-1:0]   NOP_VALUE = '0
) (
    input  logic         clk_r,
    input  logic         reset_r,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // clear wins over load so a flush can never let a new payload through
    always_ff @(posedge clk_r or posedge reset_r) begin
        if (reset_r) begin
            q <= NOP_VALUE;
        end else if (clear) begin
            q <= NOP_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/decode_pipe_reg.sv
// rtl/decode_pipe_reg.sv - decode-to-execute pipeline register with 2-entry skid, flush and bubble injection
module decode_pipe_reg
    import decode_pipe_pkg::*;
#(
    parameter int OPCODE_W   = OPCODE_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NOP_OPCODE = NOP_OPCODE_DEF
) (
    input  logic                  clk_r,
    input  logic                  reset_r,
    input  logic                  in_valid_r,
    output logic                  in_ready_r,
    input  logic [OPCODE_W-1:0]   opcode_in_d_r,
    input  logic [REG_ADDR_W-1:0] dest_in_d_r,
    input  logic [REG_ADDR_W-1:0] s1_in_d_r,
    input  logic [REG_ADDR_W-1:0] s2_in_d_r,
    input  logic [DATA_W-1:0]     ime_data_in_d_r,
    input  logic                  flush_r,
    output logic                  out_valid_r,
    input  logic                  out_ready_r,
    output logic [OPCODE_W-1:0]   opcode_out_d_r,
    output logic [REG_ADDR_W-1:0] dest_out_d_r,
    output logic [REG_ADDR_W-1:0] s1_out_d_r,
    output logic [REG_ADDR_W-1:0] s2_out_d_r,
    output logic [DATA_W-1:0]     ime_data_out_d_r,
    output logic [1:0]            occupancy_r
);

    localparam int                P_W         = OPCODE_W + 3 * REG_ADDR_W + DATA_W;
    localparam logic [OPCODE_W-1:0] NOP_OP    = NOP_OPCODE[OPCODE_W-1:0];
    localparam logic [P_W-1:0]    NOP_PAYLOAD = {NOP_OP, {(P_W - OPCODE_W){1'b0}}};

    logic           main_valid;
    logic           skid_valid;
    logic           main_valid_nxt;
    logic           skid_valid_nxt;
    logic           main_load;
    logic           main_clear;
    logic           skid_load;
    logic           skid_clear;
    logic           main_from_skid;
    logic           accept;
    logic           drain;
    logic [P_W-1:0] in_payload;
    logic [P_W-1:0] main_d;
    logic [P_W-1:0] main_q;
    logic [P_W-1:0] skid_q;

    assign in_payload = {opcode_in_d_r, dest_in_d_r, s1_in_d_r, s2_in_d_r, ime_data_in_d_r};
    assign accept     = in_valid_r & in_ready_r;
    assign drain      = main_valid & out_ready_r;
    assign main_d     = main_from_skid ? skid_q : in_payload;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        if (flush_r) begin
            main_clear     = 1'b1;
            skid_clear     = 1'b1;
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (skid_valid && drain) begin
            // in_ready_r is low whenever skid is full, so no accept competes here
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            skid_valid_nxt = 1'b0;
        end else if (accept && (!main_valid || drain)) begin
            main_load      = 1'b1;
            main_valid_nxt = 1'b1;
        end else if (accept) begin
            skid_load      = 1'b1;
            skid_valid_nxt = 1'b1;
        end else if (drain) begin
            main_clear     = 1'b1;
            main_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_r or posedge reset_r) begin
        if (reset_r) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            main_valid  <= main_valid_nxt;
            skid_valid  <= skid_valid_nxt;
            in_ready_r  <= ~skid_valid_nxt;
            occupancy_r <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
        end
    end

    pipe_payload_slot #(.W(P_W), .NOP_VALUE(NOP_PAYLOAD)) u_main_slot (
        .clk_r   (clk_r),
        .reset_r (reset_r),
        .load    (main_load),
        .clear   (main_clear),
        .d       (main_d),
        .q       (main_q)
    );

    pipe_payload_slot #(.W(P_W), .NOP_VALUE(NOP_PAYLOAD)) u_skid_slot (
        .clk_r   (clk_r),
        .reset_r (reset_r),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (in_payload),
        .q       (skid_q)
    );

    assign out_valid_r = main_valid;
    assign {opcode_out_d_r, dest_out_d_r, s1_out_d_r, s2_out_d_r, ime_data_out_d_r} = main_q;

endmodule

// File: tb/tb_decode_pipe_reg.sv
// tb/tb_decode_pipe_reg.sv - self-checking bench for decode_pipe_reg
module tb_decode_pipe_reg;
    import decode_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op_in;
    logic [3:0]  dst_in;
    logic [3:0]  s1_in;
    logic [3:0]  s2_in;
    logic [31:0] imm_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  op_out;
    logic [3:0]  dst_out;
    logic [3:0]  s1_out;
    logic [3:0]  s2_out;
    logic [31:0] imm_out;
    logic [1:0]  occ;

    int total = 0;
    int bad   = 0;

    decode_pipe_reg dut (
        .clk_r            (clk),
        .reset_r          (rst),
        .in_valid_r       (in_valid),
        .in_ready_r       (in_ready),
        .opcode_in_d_r    (op_in),
        .dest_in_d_r      (dst_in),
        .s1_in_d_r        (s1_in),
        .s2_in_d_r        (s2_in),
        .ime_data_in_d_r  (imm_in),
        .flush_r          (flush),
        .out_valid_r      (out_valid),
        .out_ready_r      (out_ready),
        .opcode_out_d_r   (op_out),
        .dest_out_d_r     (dst_out),
        .s1_out_d_r       (s1_out),
        .s2_out_d_r       (s2_out),
        .ime_data_out_d_r (imm_out),
        .occupancy_r      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [4:0]  op;
        logic [3:0]  dst;
        logic [31:0] imm;
        logic        e_ov;
        logic [4:0]  e_op;
        logic [3:0]  e_dst;
        logic [31:0] e_imm;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic fl, input logic ordy, input logic [4:0] op,
                       input logic [3:0] dst, input logic [31:0] imm, input logic e_ov,
                       input logic [4:0] e_op, input logic [3:0] e_dst, input logic [31:0] e_imm,
                       input logic [1:0] e_occ, input logic e_ir);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.op = op; v.dst = dst; v.imm = imm;
        v.e_ov = e_ov; v.e_op = e_op; v.e_dst = e_dst; v.e_imm = e_imm; v.e_occ = e_occ; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic fl, input logic ordy, input logic [4:0] op,
                         input logic [3:0] dst, input logic [31:0] imm);
        in_valid  = iv;
        flush     = fl;
        out_ready = ordy;
        op_in     = op;
        dst_in    = dst;
        s1_in     = dst + 4'd1;
        s2_in     = dst + 4'd2;
        imm_in    = imm;
    endtask

    logic [48:0] model_q[$];
    logic [48:0] exp_pl;
    logic [48:0] act_pl;
    logic        m_acc;
    logic        m_drn;
    logic [3:0]  exp_s1;
    logic [3:0]  exp_s2;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
        rst = 1'b1;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_opcode", 64'(op_out), 64'd0);
        chk("reset_imm", 64'(imm_out), 64'd0);
        chk("reset_occ", 64'(occ), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // streaming: each instruction visible one cycle after acceptance
        for (int n = 1; n <= 8; n++)
            add(1, 0, 1, 5'(n), 4'(n), 32'h1000 + 32'(n), 1, 5'(n), 4'(n), 32'h1000 + 32'(n), 2'd1, 1);
        add(0, 0, 1, 5'd0, 4'd0, 32'd0, 0, 5'd0, 4'd0, 32'd0, 2'd0, 1);
        // backpressure fills skid, then drains in order
        add(1, 0, 0, 5'd3, 4'd5, 32'hDEADBEEF, 1, 5'd3, 4'd5, 32'hDEADBEEF, 2'd1, 1);
        add(1, 0, 0, 5'd4, 4'd1, 32'h4,        1, 5'd3, 4'd5, 32'hDEADBEEF, 2'd2, 0);
        add(1, 0, 0, 5'd7, 4'd2, 32'h7,        1, 5'd3, 4'd5, 32'hDEADBEEF, 2'd2, 0);
        add(0, 0, 1, 5'd0, 4'd0, 32'd0,        1, 5'd4, 4'd1, 32'h4,        2'd1, 1);
        add(0, 0, 1, 5'd0, 4'd0, 32'd0,        0, 5'd0, 4'd0, 32'd0,        2'd0, 1);
        // bubble after a lone instruction
        add(1, 0, 0, 5'd9, 4'd3, 32'h99, 1, 5'd9, 4'd3, 32'h99, 2'd1, 1);
        add(0, 0, 1, 5'd0, 4'd0, 32'd0,  0, 5'd0, 4'd0, 32'd0,  2'd0, 1);
        // flush with full skid and a pending input
        add(1, 0, 0, 5'd10, 4'd6, 32'hA, 1, 5'd10, 4'd6, 32'hA, 2'd1, 1);
        add(1, 0, 0, 5'd11, 4'd7, 32'hB, 1, 5'd10, 4'd6, 32'hA, 2'd2, 0);
        add(1, 1, 1, 5'd12, 4'd8, 32'hC, 0, 5'd0,  4'd0, 32'd0, 2'd0, 1);
        // flush discards a same-cycle accept
        add(1, 0, 0, 5'd13, 4'd9, 32'hD, 1, 5'd13, 4'd9, 32'hD, 2'd1, 1);
        add(1, 1, 0, 5'd14, 4'hA, 32'hE, 0, 5'd0,  4'd0, 32'd0, 2'd0, 1);
        add(0, 0, 1, 5'd0,  4'd0, 32'd0, 0, 5'd0,  4'd0, 32'd0, 2'd0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].fl, vecs[i].ordy, vecs[i].op, vecs[i].dst, vecs[i].imm);
            @(posedge clk); #1;
            exp_s1 = vecs[i].e_ov ? vecs[i].e_dst + 4'd1 : 4'd0;
            exp_s2 = vecs[i].e_ov ? vecs[i].e_dst + 4'd2 : 4'd0;
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_opcode", i), 64'(op_out), 64'(vecs[i].e_op));
            chk($sformatf("v%0d_dest", i), 64'(dst_out), 64'(vecs[i].e_dst));
            chk($sformatf("v%0d_s1", i), 64'(s1_out), 64'(exp_s1));
            chk($sformatf("v%0d_s2", i), 64'(s2_out), 64'(exp_s2));
            chk($sformatf("v%0d_imm", i), 64'(imm_out), 64'(vecs[i].e_imm));
            chk($sformatf("v%0d_occ", i), 64'(occ), 64'(vecs[i].e_occ));
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
        end

        // async reset in the middle of a cycle while two entries are held
        drive(1'b1, 1'b0, 1'b0, 5'd21, 4'd1, 32'h21);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 5'd22, 4'd2, 32'h22);
        @(posedge clk); #1;
        chk("pre_reset_occ", 64'(occ), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_opcode", 64'(op_out), 64'd0);
        chk("async_reset_imm", 64'(imm_out), 64'd0);
        chk("async_reset_occ", 64'(occ), 64'd0);
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("held_reset_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
        @(posedge clk); #1;
        chk("post_reset_occ", 64'(occ), 64'd0);

        // randomized traffic against a queue model
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            exp_pl = (model_q.size() > 0) ? model_q[0] : pack_payload(5'd0, 4'd0, 4'd0, 4'd0, 32'd0);
            act_pl = {op_out, dst_out, s1_out, s2_out, imm_out};
            chk("rnd_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            chk("rnd_payload", 64'(act_pl), 64'(exp_pl));
            chk("rnd_occ", 64'(occ), 64'(model_q.size()));
            chk("rnd_in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
                  5'($urandom), 4'($urandom), $urandom);
            m_acc = in_valid && (model_q.size() < 2);
            m_drn = out_ready && (model_q.size() > 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_drn) void'(model_q.pop_front());
                if (m_acc) model_q.push_back(pack_payload(op_in, dst_in, s1_in, s2_in, imm_in));
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
